// File: rtl/exe_muldiv_seq_if.sv
// rtl/exe_muldiv_seq_if.sv - EX-stage request/response bundle for the mul/div sequencer
//
// Purpose: groups the EX-side request (start/op/operands/flush) and the
// sequencer response (busy/done/result) so they travel as one port.
// Signals:
//   start   EX request, only sampled while the sequencer is idle
//   op      RV32M funct3
//   a, b    forwarded rs1 / rs2
//   flush   pipeline flush, kills any in-flight operation
//   busy    stall request to the hazard unit
//   done    one-cycle pulse, result valid
//   result  registered result
// Modports: master = EX stage, slave = sequencer.

interface exe_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, result
  );
endinterface

// File: rtl/exe_muldiv_seq.sv
// rtl/exe_muldiv_seq.sv - iterative RV32M multiply/divide sequencer for the EX stage
//
// Purpose: radix-2 shift-add multiply and restoring shift-subtract divide on
// operand magnitudes, XLEN iterations, sign fix-up when the result is loaded.
// Divide-by-zero and signed overflow skip the iterations entirely.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    slave side of exe_muldiv_seq_if (start/op/a/b/flush in,
//          busy/done/result out)

module exe_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  exe_muldiv_seq_if.slave    bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  // hi: multiply accumulator / divide partial remainder
  // lo: multiplier being shifted out / dividend shifting into quotient
  logic [XLEN-1:0] hi, lo;
  logic [XLEN-1:0] mag_b;
  logic            sa, sb;
  logic [XLEN-1:0] result_q;

  // operand decode on the live EX inputs
  logic            sign_a_en, sign_b_en;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            accept, div_zero, div_ovf, special;

  always_comb begin
    sign_a_en = (bus.op == OP_MUL) || (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                (bus.op == OP_DIV) || (bus.op == OP_REM);
    sign_b_en = (bus.op == OP_MUL) || (bus.op == OP_MULH) ||
                (bus.op == OP_DIV) || (bus.op == OP_REM);
    a_neg     = sign_a_en && bus.a[XLEN-1];
    b_neg     = sign_b_en && bus.b[XLEN-1];
    a_mag     = a_neg ? (~bus.a + 1'b1) : bus.a;
    b_mag     = b_neg ? (~bus.b + 1'b1) : bus.b;
    accept    = (state == IDLE) && bus.start && !bus.flush;
    div_zero  = bus.op[2] && (bus.b == '0);
    div_ovf   = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                (bus.a == MIN_NEG) && (bus.b == '1);
    special   = div_zero || div_ovf;
  end

  // one iteration of each datapath
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift, div_trial;
  logic              div_ge;
  logic [XLEN-1:0]   hi_nx, lo_nx;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, final_res;

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : '0);
    div_shift = {hi, lo[XLEN-1]};
    div_trial = div_shift - {1'b0, mag_b};
    // a clear top bit means no borrow: the divisor fits, keep the difference
    div_ge    = !div_trial[XLEN];
    if (op_q[2]) begin
      hi_nx = div_ge ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
      lo_nx = {lo[XLEN-2:0], div_ge};
    end else begin
      hi_nx = mul_sum[XLEN:1];
      lo_nx = {mul_sum[0], lo[XLEN-1:1]};
    end

    prod   = {hi_nx, lo_nx};
    prod_s = (sa ^ sb) ? (~prod + 1'b1) : prod;
    quo_s  = (sa ^ sb) ? (~lo_nx + 1'b1) : lo_nx;
    rem_s  = sa ? (~hi_nx + 1'b1) : hi_nx;

    if (op_q[2])
      final_res = op_q[1] ? rem_s : quo_s;
    else if (op_q[1:0] == 2'b00)
      final_res = prod_s[XLEN-1:0];
    else
      final_res = prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = special ? DONE : CALC;
      CALC: if (cnt == LAST) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.flush)
      state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      op_q     <= '0;
      hi       <= '0;
      lo       <= '0;
      mag_b    <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      result_q <= '0;
    end else if (bus.flush) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= bus.op;
            hi    <= '0;
            lo    <= a_mag;
            mag_b <= b_mag;
            sa    <= a_neg;
            sb    <= b_neg;
            cnt   <= '0;
            // op[1] separates REM/REMU from DIV/DIVU
            if (div_zero)
              result_q <= bus.op[1] ? bus.a : '1;
            else if (div_ovf)
              result_q <= bus.op[1] ? '0 : MIN_NEG;
          end
        end
        CALC: begin
          hi <= hi_nx;
          lo <= lo_nx;
          if (cnt == LAST) begin
            cnt      <= '0;
            result_q <= final_res;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // busy is combinational from start so the stall covers the request cycle
  assign bus.busy   = rst_n && (accept || (state == CALC));
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_exe_muldiv_seq.sv
// tb/tb_exe_muldiv_seq.sv - directed self-checking bench for exe_muldiv_seq

module tb_exe_muldiv_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   dcount;

  exe_muldiv_seq_if #(.XLEN(32)) mif ();

  exe_muldiv_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // start in cycle N, expect done after lat cycles with result exp
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit hold);
    int  cyc;
    bit  busy_ok;
    mif.op    = op;
    mif.a     = a;
    mif.b     = b;
    mif.start = 1'b1;
    #1;
    check({tag, " busy@N"}, 32'(mif.busy), 32'd1);
    step();
    if (!hold) mif.start = 1'b0;
    mif.a   = 32'hDEAD_BEEF;
    mif.b   = 32'h0BAD_F00D;
    mif.op  = 3'b111;
    #1;
    cyc     = 1;
    busy_ok = 1'b1;
    while (!mif.done && cyc < 40) begin
      if (!mif.busy) busy_ok = 1'b0;
      step();
      #1;
      cyc++;
    end
    check({tag, " done"}, 32'(mif.done), 32'd1);
    check({tag, " latency"}, 32'(cyc), 32'(lat));
    check({tag, " result"}, mif.result, exp);
    check({tag, " busy@done"}, 32'(mif.busy), 32'd0);
    if (lat > 1) check({tag, " busy held"}, 32'(busy_ok), 32'd1);
    step();
    if (hold) mif.start = 1'b0;
    #1;
    check({tag, " done pulse"}, 32'(mif.done), 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    mif.start = 1'b0;
    mif.flush = 1'b0;
    mif.op    = 3'b000;
    mif.a     = '0;
    mif.b     = '0;
    repeat (3) step();
    #1;
    check("reset busy", 32'(mif.busy), 32'd0);
    check("reset done", 32'(mif.done), 32'd0);
    check("reset result", mif.result, 32'd0);
    rst_n = 1'b1;
    step();

    run_op("MUL 7*-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0);
    run_op("MULH min*min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b0);
    run_op("MULHU max*max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
    run_op("MULHSU -1*2", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
    run_op("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
    run_op("DIVU 100/7", 3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    run_op("REMU 100/7", 3'b111, 32'd100, 32'd7, 32'd2, 33, 1'b0);

    // flush at N+10 kills the multiply; previous result (2) must survive
    mif.op    = 3'b000;
    mif.a     = 32'd5;
    mif.b     = 32'd9;
    mif.start = 1'b1;
    step();
    mif.start = 1'b0;
    repeat (9) step();
    mif.flush = 1'b1;
    step();
    mif.flush = 1'b0;
    #1;
    check("flush busy", 32'(mif.busy), 32'd0);
    check("flush done", 32'(mif.done), 32'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mif.done) dcount++;
    end
    check("flush no done", 32'(dcount), 32'd0);
    check("flush result kept", mif.result, 32'd2);

    // start and flush together in IDLE: nothing accepted
    mif.op    = 3'b101;
    mif.a     = 32'd50;
    mif.b     = 32'd0;
    mif.start = 1'b1;
    mif.flush = 1'b1;
    #1;
    check("start+flush busy", 32'(mif.busy), 32'd0);
    step();
    mif.start = 1'b0;
    mif.flush = 1'b0;
    #1;
    check("start+flush busy after", 32'(mif.busy), 32'd0);
    check("start+flush done", 32'(mif.done), 32'd0);
    check("start+flush result", mif.result, 32'd2);

    run_op("DIVU x/0", 3'b101, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("REM x/0", 3'b110, 32'h0000_1234, 32'd0, 32'h0000_1234, 1, 1'b0);
    run_op("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    run_op("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1'b0);

    // start held through CALC and DONE: exactly one completion
    run_op("MUL held", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b1);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mif.done) dcount++;
    end
    check("held single done", 32'(dcount), 32'd0);

    // reset at N+5 abandons the operation
    mif.op    = 3'b000;
    mif.a     = 32'd3;
    mif.b     = 32'd4;
    mif.start = 1'b1;
    step();
    mif.start = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("midreset busy", 32'(mif.busy), 32'd0);
    step();
    #1;
    check("midreset done", 32'(mif.done), 32'd0);
    check("midreset result", mif.result, 32'd0);
    rst_n = 1'b1;
    step();
    run_op("DIVU after reset", 3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
